// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path (and the planned transmit path).
//   - rx_state_e : receiver FSM states
//   - OVERSAMPLE : ticks per bit period
//   - MID_SAMPLE : ticks from start-bit falling edge to start-bit midpoint
//   - calc_div() : clock-to-oversample-tick divider
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned MID_SAMPLE = 8;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreak,
    StParity
  } rx_state_e;

  // Integer-truncated divider, clamped to 1 so a too-fast baud never yields a zero-length tick.
  function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned d;
    d = clk_hz / (baud * OVERSAMPLE);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: synchronous first-word-fall-through byte FIFO.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push/wdata write request and byte; dropped when full unless a pop happens in the same cycle
//   pop        read request; ignored when empty
//   rdata      head byte (0 when empty)
//   full/empty occupancy flags
//   count      current occupancy, 0..DEPTH
// DEPTH must be a power of two, minimum 2.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               wdata,
  input  logic                     pop,
  output logic [7:0]               rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign pop_ok  = pop & ~empty;
  // A pop frees the slot the push needs, so a full FIFO still accepts a simultaneous push.
  assign push_ok = push & (~full | pop_ok);

  assign rdata = empty ? 8'h00 : mem_q[rd_ptr_q];
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      // Pointers wrap naturally because DEPTH is a power of two.
      if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 16x-oversampling UART receiver feeding a first-word-fall-through byte FIFO.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx         serial line, idle high, asynchronous to clk
//   rd_en      pop request, ignored while rd_valid=0
//   rd_data    FIFO head byte, valid while rd_valid=1
//   rd_valid   FIFO not empty
//   count      FIFO occupancy
//   frame_err  one-cycle pulse: bad stop bit (or bad parity)
//   overrun    one-cycle pulse: received byte dropped because the FIFO was full
// Build option: define UART_RX_PARITY_EN for 8E1 framing; otherwise 8N1.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ     = 100000000,
  parameter int unsigned BAUD       = 9600,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rx,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          rd_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_err,
  output logic                          overrun
);

  localparam int unsigned DIV = calc_div(CLK_HZ, BAUD);
  localparam int unsigned TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DIV - 1);
  localparam logic [3:0]    MID_LAST  = 4'(MID_SAMPLE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(OVERSAMPLE - 1);

  logic          rx_meta_q, rx_s_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;

  rx_state_e     state_q, state_d;
  logic [3:0]    phase_q, phase_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          push_q, push_d;
  logic          frame_err_q, frame_err_d;
  logic          overrun_q;
`ifdef UART_RX_PARITY_EN
  logic          parity_ok_q, parity_ok_d;
`endif

  logic          fifo_full, fifo_empty;

  // Synchronizer resets high so reset release never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tick_cnt_q <= '0;
    else     tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    push_d      = 1'b0;
    frame_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_ok_d = parity_ok_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (!rx_s_q) begin
          state_d = StStart;
          phase_d = '0;
        end
      end
      StStart: begin
        if (tick) begin
          if (phase_q == MID_LAST) begin
            // Realign phase so later samples land on bit midpoints.
            phase_d   = '0;
            bit_cnt_d = '0;
            state_d   = rx_s_q ? StIdle : StData;
          end else begin
            phase_d = phase_q + 1'b1;
          end
        end
      end
      StData: begin
        if (tick) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == BIT_LAST) begin
            shift_d   = {rx_s_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bit_cnt_q == 3'd7) state_d = StParity;
`else
            if (bit_cnt_q == 3'd7) state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (tick) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == BIT_LAST) begin
            // Even parity: data ones plus the parity bit must be even.
            parity_ok_d = ~(^shift_q ^ rx_s_q);
            state_d     = StStop;
          end
        end
      end
`endif
      StStop: begin
        if (tick) begin
          phase_d = phase_q + 1'b1;
          if (phase_q == BIT_LAST) begin
            if (!rx_s_q) begin
              frame_err_d = 1'b1;
              state_d     = StBreak;
            end else begin
              state_d = StIdle;
`ifdef UART_RX_PARITY_EN
              if (parity_ok_q) push_d = 1'b1;
              else             frame_err_d = 1'b1;
`else
              push_d = 1'b1;
`endif
            end
          end
        end
      end
      StBreak: begin
        // Hold here through a stuck-low line so it is reported only once.
        if (rx_s_q) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      push_q      <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_ok_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      push_q      <= push_d;
      frame_err_q <= frame_err_d;
`ifdef UART_RX_PARITY_EN
      parity_ok_q <= parity_ok_d;
`endif
    end
  end

  // shift_q is stable while push_q is high (FSM is back in IDLE or BREAK).
  byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .wdata (shift_q),
    .pop   (rd_en),
    .rdata (rd_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overrun_q <= 1'b0;
    else     overrun_q <= push_q & fifo_full & ~(rd_en & ~fifo_empty);
  end

  assign rd_valid  = ~fifo_empty;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
`timescale 1ns/1ps
module tb_uart_rx_fifo;

  localparam int unsigned CLK_HZ  = 1600000;
  localparam int unsigned BAUD    = 10000;
  localparam int unsigned DEPTH   = 4;
  localparam int          BIT_CYC = 160;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [2:0] count;
  logic       frame_err;
  logic       overrun;

  always #5 clk = ~clk;

  uart_rx_fifo #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .count     (count),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  int         errors = 0;
  int         checks = 0;
  int         fe_cnt = 0;
  int         ov_cnt = 0;
  int         cyc    = 0;
  logic [7:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Monitor: counts error pulses and checks every accepted pop against the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      if (rd_en && rd_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pop_unexpected: got 0x%0h expected no data", rd_data);
        end else begin
          check("pop_data", {24'h0, rd_data}, {24'h0, exp_q.pop_front()});
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx = b;
    wait_cyc(BIT_CYC);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(^d);
`endif
    drive_bit(stop_bit);
  endtask

  task automatic pop_n(input int n);
    repeat (n) begin
      rd_en = 1'b1;
      wait_cyc(1);
    end
    rd_en = 1'b0;
    wait_cyc(1);
  endtask

  int t0, lat, fe0, ov0;
  bit seen;

  initial begin
    rst   = 1'b1;
    rx    = 1'b1;
    rd_en = 1'b0;
    wait_cyc(5);
    check("reset_rd_valid", {31'h0, rd_valid}, 0);
    check("reset_count", {29'h0, count}, 0);
    check("reset_rd_data", {24'h0, rd_data}, 0);
    check("reset_frame_err", {31'h0, frame_err}, 0);
    check("reset_overrun", {31'h0, overrun}, 0);
    rst = 1'b0;
    wait_cyc(20);

    // Single byte with latency window.
    exp_q.push_back(8'hA5);
    t0 = cyc;
    fork
      send_frame(8'hA5, 1'b1);
    join_none
    seen = 1'b0;
    for (int i = 0; i < 2500 && !seen; i++) begin
      @(negedge clk);
      if (rd_valid) seen = 1'b1;
    end
    lat = cyc - t0;
    check("a5_arrived", {31'h0, seen}, 1);
    check("a5_latency_window", {31'h0, (lat >= 1400 && lat <= 1600)}, 1);
    wait fork;
    #1;
    check("a5_count", {29'h0, count}, 1);
    check("a5_no_frame_err", fe_cnt, 0);
    check("a5_no_overrun", ov_cnt, 0);
    pop_n(1);

    // Back-to-back bytes, no reads.
    exp_q.push_back(8'h3C); send_frame(8'h3C, 1'b1);
    exp_q.push_back(8'h00); send_frame(8'h00, 1'b1);
    exp_q.push_back(8'hFF); send_frame(8'hFF, 1'b1);
    check("b2b_count", {29'h0, count}, 3);
    pop_n(3);
    check("b2b_drained_valid", {31'h0, rd_valid}, 0);
    check("b2b_drained_count", {29'h0, count}, 0);

    // Overrun: fill, then a fifth byte with no pop.
    exp_q.push_back(8'h11); send_frame(8'h11, 1'b1);
    exp_q.push_back(8'h22); send_frame(8'h22, 1'b1);
    exp_q.push_back(8'h33); send_frame(8'h33, 1'b1);
    exp_q.push_back(8'h44); send_frame(8'h44, 1'b1);
    check("fill_count", {29'h0, count}, 4);
    ov0 = ov_cnt;
    send_frame(8'h55, 1'b1);
    wait_cyc(5);
    check("overrun_pulses_once", ov_cnt - ov0, 1);
    check("overrun_count_kept", {29'h0, count}, 4);
    check("overrun_head_kept", {24'h0, rd_data}, 32'h11);

    // Full FIFO with a pop on the push cycle: both succeed.
    ov0 = ov_cnt;
    exp_q.push_back(8'h55);
    fork
      send_frame(8'h55, 1'b1);
    join_none
    seen = 1'b0;
    for (int i = 0; i < 2500 && !seen; i++) begin
      @(posedge clk);
      #1;
      if (dut.push_q) begin
        seen  = 1'b1;
        rd_en = 1'b1;
        wait_cyc(1);
        rd_en = 1'b0;
      end
    end
    check("pop_push_seen", {31'h0, seen}, 1);
    wait fork;
    wait_cyc(3);
    check("pop_push_no_overrun", ov_cnt - ov0, 0);
    check("pop_push_count", {29'h0, count}, 4);
    pop_n(4);
    check("after_overrun_empty", {31'h0, rd_valid}, 0);

    // Short low glitch on idle line.
    fe0 = fe_cnt;
    rx = 1'b0;
    wait_cyc(40);
    rx = 1'b1;
    wait_cyc(200);
    check("glitch_no_push", {29'h0, count}, 0);
    check("glitch_no_frame_err", fe_cnt - fe0, 0);
    exp_q.push_back(8'h81); send_frame(8'h81, 1'b1);
    check("after_glitch_count", {29'h0, count}, 1);
    pop_n(1);

    // Framing error followed by a long break.
    fe0 = fe_cnt;
    send_frame(8'h7E, 1'b0);
    rx = 1'b0;
    wait_cyc(2000);
    rx = 1'b1;
    wait_cyc(200);
    check("break_one_frame_err", fe_cnt - fe0, 1);
    check("break_no_push", {29'h0, count}, 0);
    exp_q.push_back(8'h12); send_frame(8'h12, 1'b1);
    check("after_break_count", {29'h0, count}, 1);
    pop_n(1);

    // Reset mid-frame with bytes queued.
    exp_q.push_back(8'hAA); send_frame(8'hAA, 1'b1);
    exp_q.push_back(8'hBB); send_frame(8'hBB, 1'b1);
    check("pre_reset_count", {29'h0, count}, 2);
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(i[0] ? 1'b0 : 1'b1);
    rx = 1'b1;
    wait_cyc(80);
    rst = 1'b1;
    exp_q.delete();
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(2);
    check("reset_flush_count", {29'h0, count}, 0);
    check("reset_flush_valid", {31'h0, rd_valid}, 0);
    wait_cyc(200);
    exp_q.push_back(8'h42); send_frame(8'h42, 1'b1);
    check("after_reset_count", {29'h0, count}, 1);
    pop_n(1);

`ifdef UART_RX_PARITY_EN
    // 0x42 has two ones; a parity bit of 1 is wrong for even parity.
    fe0 = fe_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(i == 1 || i == 6);
    drive_bit(1'b1);
    drive_bit(1'b1);
    wait_cyc(20);
    check("parity_frame_err", fe_cnt - fe0, 1);
    check("parity_no_push", {29'h0, count}, 0);
`endif

    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
